// File: rtl/epmp_mdr_ctrl.sv
// EPMP memory data register and bus-cycle controller.
// Runs byte/word read and write cycles on the 8-bit memory bus.
module epmp_mdr_ctrl #(
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] A,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic        word,
   input  logic [7:0]  IBL,
   input  logic [7:0]  IBH,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   output logic        mem_oe,
   output logic        mem_we,
   output logic        busy,
   output logic        done,
   output logic [7:0]  MDR_L,
   output logic [7:0]  MDR_H
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] STROBE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;
   localparam logic [3:0] WS     = 4'(WAIT_STATES);

   logic [1:0]  state;
   logic        hi_sel;
   logic [3:0]  wcnt;
   logic        op_rd;
   logic        word_q;
   logic [15:0] a_q;
   logic [7:0]  ibl_q;
   logic [7:0]  ibh_q;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hi_sel   <= 1'b0;
         wcnt     <= 4'd0;
         op_rd    <= 1'b0;
         word_q   <= 1'b0;
         a_q      <= 16'd0;
         ibl_q    <= 8'd0;
         ibh_q    <= 8'd0;
         mem_addr <= 16'd0;
         mem_dout <= 8'd0;
         mem_oe   <= 1'b0;
         mem_we   <= 1'b0;
         done     <= 1'b0;
         MDR_L    <= 8'd0;
         MDR_H    <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_req || wr_req) begin
                  op_rd    <= rd_req;
                  word_q   <= word;
                  a_q      <= A;
                  ibl_q    <= IBL;
                  ibh_q    <= IBH;
                  hi_sel   <= 1'b0;
                  mem_addr <= A;
                  if (!rd_req)
                     mem_dout <= IBL;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               wcnt   <= WS;
               mem_oe <= op_rd;
               mem_we <= !op_rd;
               state  <= STROBE;
            end
            STROBE: begin
               if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  mem_oe <= 1'b0;
                  mem_we <= 1'b0;
                  if (op_rd) begin
                     if (hi_sel) begin
                        MDR_H <= mem_din;
                     end else begin
                        MDR_L <= mem_din;
                        MDR_H <= 8'd0;
                     end
                  end
                  // Second byte goes back through SETUP so strobes drop across the address change
                  if (word_q && !hi_sel) begin
                     hi_sel   <= 1'b1;
                     mem_addr <= a_q + 16'd1;
                     if (!op_rd)
                        mem_dout <= ibh_q;
                     state    <= SETUP;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done   <= 1'b0;
               hi_sel <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_epmp_mdr_ctrl.sv
// Self-checking bench for epmp_mdr_ctrl: directed plus random accesses
// against a byte-array memory model.
module tb_epmp_mdr_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] A;
   logic        rd_req, wr_req, word;
   logic [7:0]  IBL, IBH;
   logic [15:0] mem_addr;
   logic [7:0]  mem_dout, mem_din;
   logic        mem_oe, mem_we, busy, done;
   logic [7:0]  MDR_L, MDR_H;

   logic [15:0] A_z;
   logic        rd_req_z, wr_req_z, word_z;
   logic [7:0]  IBL_z, IBH_z;
   logic [15:0] mem_addr_z;
   logic [7:0]  mem_dout_z, mem_din_z;
   logic        mem_oe_z, mem_we_z, busy_z, done_z;
   logic [7:0]  MDR_L_z, MDR_H_z;

   logic [7:0]  tb_mem [0:65535];
   logic [7:0]  exp_l, exp_h;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   assign mem_din   = tb_mem[mem_addr];
   assign mem_din_z = tb_mem[mem_addr_z];

   epmp_mdr_ctrl #(.WAIT_STATES(W)) dut (
      .clk(clk), .rst(rst), .A(A), .rd_req(rd_req), .wr_req(wr_req),
      .word(word), .IBL(IBL), .IBH(IBH), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_din(mem_din), .mem_oe(mem_oe),
      .mem_we(mem_we), .busy(busy), .done(done), .MDR_L(MDR_L),
      .MDR_H(MDR_H)
   );

   epmp_mdr_ctrl #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .A(A_z), .rd_req(rd_req_z), .wr_req(wr_req_z),
      .word(word_z), .IBL(IBL_z), .IBH(IBH_z), .mem_addr(mem_addr_z),
      .mem_dout(mem_dout_z), .mem_din(mem_din_z), .mem_oe(mem_oe_z),
      .mem_we(mem_we_z), .busy(busy_z), .done(done_z), .MDR_L(MDR_L_z),
      .MDR_H(MDR_H_z)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input bit rd, input bit wr, input bit wd,
                         input logic [15:0] a, input logic [7:0] l,
                         input logic [7:0] h, input bit poke);
      logic [15:0] wa[$];
      logic [7:0]  wdat[$];
      logic [15:0] ra[$];
      logic [15:0] a1;
      logic [15:0] p_addr;
      logic [7:0]  p_dout;
      bit          p_oe, p_we, excl, nobusy, unstable, is_rd;
      int          n, oe_c, we_c, strobes, exp_lat;
      a1 = a + 16'd1;
      is_rd = rd;
      p_oe = 0; p_we = 0; excl = 0; nobusy = 0; unstable = 0;
      oe_c = 0; we_c = 0;
      p_addr = '0; p_dout = '0;
      exp_lat = wd ? 2 * W + 5 : W + 3;
      strobes = (wd ? 2 : 1) * (W + 1);
      rd_req = rd; wr_req = wr; word = wd; A = a; IBL = l; IBH = h;
      cyc();
      rd_req = 0; wr_req = 0;
      A = 16'($urandom); IBL = 8'($urandom); IBH = 8'($urandom);
      word = 1'($urandom);
      for (n = 1; n <= 40; n++) begin
         if (mem_oe && mem_we) excl = 1;
         if (!busy) nobusy = 1;
         if (mem_oe) oe_c++;
         if (mem_we) we_c++;
         if ((mem_oe && p_oe) || (mem_we && p_we))
            if (mem_addr !== p_addr || mem_dout !== p_dout) unstable = 1;
         if (mem_we && !p_we) begin
            wa.push_back(mem_addr);
            wdat.push_back(mem_dout);
         end
         if (mem_oe && !p_oe) ra.push_back(mem_addr);
         if (done) break;
         if (poke && n == 3) wr_req = 1;
         if (poke && n == 4) wr_req = 0;
         p_oe = mem_oe; p_we = mem_we;
         p_addr = mem_addr; p_dout = mem_dout;
         cyc();
      end
      wr_req = 0;
      chk("latency", 32'(n), 32'(exp_lat));
      chk("oe_we_exclusive", 32'(excl), 0);
      chk("busy_during_op", 32'(nobusy), 0);
      chk("strobe_stable", 32'(unstable), 0);
      if (is_rd) begin
         chk("rd_oe_cycles", 32'(oe_c), 32'(strobes));
         chk("rd_we_cycles", 32'(we_c), 0);
         chk("rd_pulses", 32'(ra.size()), wd ? 2 : 1);
         chk("rd_addr0", 32'(ra[0]), 32'(a));
         if (wd) chk("rd_addr1", 32'(ra[1]), 32'(a1));
         exp_l = tb_mem[a];
         exp_h = wd ? tb_mem[a1] : 8'h00;
      end else begin
         chk("wr_we_cycles", 32'(we_c), 32'(strobes));
         chk("wr_oe_cycles", 32'(oe_c), 0);
         chk("wr_pulses", 32'(wa.size()), wd ? 2 : 1);
         chk("wr_addr0", 32'(wa[0]), 32'(a));
         chk("wr_data0", 32'(wdat[0]), 32'(l));
         if (wd) begin
            chk("wr_addr1", 32'(wa[1]), 32'(a1));
            chk("wr_data1", 32'(wdat[1]), 32'(h));
         end
         tb_mem[a] = l;
         if (wd) tb_mem[a1] = h;
      end
      chk("mdr_l", 32'(MDR_L), 32'(exp_l));
      chk("mdr_h", 32'(MDR_H), 32'(exp_h));
      cyc();
      chk("done_one_cycle", 32'(done), 0);
      chk("idle_after_done", 32'(busy), 0);
      if (poke) begin
         cyc();
         chk("poke_ignored", 32'(busy), 0);
      end
   endtask

   initial begin
      int n, k;
      bit seen_done;
      for (int i = 0; i < 65536; i++) tb_mem[i] = 8'($urandom);
      tb_mem[16'h1234] = 8'hA5;
      tb_mem[16'hFFFF] = 8'h11;
      tb_mem[16'h0000] = 8'h22;
      rst = 1; A = 0; rd_req = 0; wr_req = 0; word = 0; IBL = 0; IBH = 0;
      A_z = 0; rd_req_z = 0; wr_req_z = 0; word_z = 0; IBL_z = 0; IBH_z = 0;
      exp_l = 0; exp_h = 0;
      repeat (3) cyc();
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_dout", 32'(mem_dout), 0);
      chk("rst_oe_we", 32'({mem_oe, mem_we}), 0);
      chk("rst_busy_done", 32'({busy, done}), 0);
      chk("rst_mdr", 32'({MDR_H, MDR_L}), 0);
      rst = 0;
      cyc();

      run_op(1, 0, 0, 16'h1234, 8'h00, 8'h00, 0);
      run_op(1, 0, 1, 16'hFFFF, 8'h00, 8'h00, 0);
      run_op(0, 1, 1, 16'h0100, 8'h3C, 8'hC3, 0);
      run_op(1, 1, 0, 16'h0100, 8'h77, 8'h88, 0);
      run_op(1, 0, 0, 16'h4321, 8'h00, 8'h00, 1);

      for (int i = 0; i < 24; i++) begin
         int op;
         logic [15:0] ra;
         op = $urandom_range(0, 2);
         ra = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
         run_op(op != 1, op != 0, 1'($urandom), ra,
                8'($urandom), 8'($urandom), 1'($urandom));
      end

      rd_req = 1; word = 1; A = 16'h2000;
      cyc();
      rd_req = 0;
      cyc();
      cyc();
      chk("pre_rst_oe", 32'(mem_oe), 1);
      rst = 1;
      cyc();
      rst = 0;
      chk("abort_strobes", 32'({mem_oe, mem_we}), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      exp_l = 0; exp_h = 0;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) seen_done = 1;
         cyc();
      end
      chk("abort_no_done", 32'(seen_done), 0);

      rd_req_z = 1; A_z = 16'h0042;
      cyc();
      rd_req_z = 0;
      k = 41;
      for (n = 1; n <= 40; n++) begin
         if (done_z) begin
            k = n;
            break;
         end
         cyc();
      end
      chk("w0_latency", 32'(k), 3);
      chk("w0_mdr_l", 32'(MDR_L_z), 32'(tb_mem[16'h0042]));
      chk("w0_mdr_h", 32'(MDR_H_z), 0);

      run_op(1, 0, 0, 16'h1234, 8'h00, 8'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/epmp_mdr_ctrl.md
Name: epmp_mdr_ctrl

Overview:
Memory data register and bus-cycle controller for the EPMP datapath. It takes the 16-bit address held by the memory address register and runs read or write cycles on the external 8-bit memory bus, inserting a configurable number of wait states. Write data comes from the internal bus bytes. Read data is assembled from one or two memory bytes and returned as low/high internal-bus bytes. The block is the data-side counterpart of the address register: the address register splits the internal bus into an address, and this block merges memory bytes back onto the internal bus.

Parameters:
WAIT_STATES, 2, extra strobe cycles per byte access (legal range 0..15).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
A  input  16  access address from the memory address register; sampled only when a request is accepted.
rd_req  input  1  read request; sampled in IDLE only.
wr_req  input  1  write request; sampled in IDLE only.
word  input  1  1 = two-byte access (A, then A+1); 0 = single byte at A.
IBL  input  8  write data, low byte (to A).
IBH  input  8  write data, high byte (to A+1; word writes only).
mem_addr  output  16  external memory address (registered).
mem_dout  output  8  external write data (registered).
mem_din  input  8  external read data.
mem_oe  output  1  read strobe, active-high.
mem_we  output  1  write strobe, active-high.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
MDR_L  output  8  read data low byte.
MDR_H  output  8  read data high byte.

Behaviour:
- States: IDLE, SETUP, STROBE, DONE. Byte index bit hi_sel; 4-bit wait counter.
- Reset: state IDLE. mem_addr, mem_dout, MDR_L and MDR_H are 0. mem_oe, mem_we, busy, done and hi_sel are 0.
- Reset mid-cycle aborts the access immediately. Strobes are low on the next cycle, and no done pulse is produced.
- IDLE, request acceptance:
  - If rd_req or wr_req is high, latch A, word, IBL, IBH and the operation, then go to SETUP.
  - rd_req has priority if both are high. The write is dropped, not queued.
- Requests in any state other than IDLE are ignored.
- SETUP (1 cycle):
  - mem_addr = A when hi_sel=0, A+1 when hi_sel=1. Arithmetic is 16-bit, so 0xFFFF+1 = 0x0000.
  - For writes, mem_dout = latched IBL or IBH according to hi_sel.
  - Both strobes are low.
- STROBE (WAIT_STATES+1 cycles): mem_oe (read) or mem_we (write) is held high.
  - mem_addr and mem_dout are stable for the whole strobe.
  - Read capture: on the final strobe cycle edge, mem_din is captured into MDR_L (hi_sel=0) or MDR_H (hi_sel=1).
- After STROBE:
  - If word=1 and hi_sel=0: set hi_sel=1 and go to SETUP. Strobes drop for that SETUP cycle, so there are never back-to-back strobes across an address change.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=1, strobes low. Then go to IDLE and clear hi_sel.
- Byte read: MDR_H is cleared to 0x00 when MDR_L is captured.
- Writes never modify MDR_L or MDR_H. Both registers hold their value until the next read.
- mem_oe and mem_we are never high in the same cycle.
- Latency, counting clocks after the request-accept edge until done is high: byte access = WAIT_STATES+3; word access = 2*WAIT_STATES+5. With the default (2): 5 and 9.
- The earliest new request is accepted on the edge ending the cycle after DONE, i.e. in IDLE.

Test Plan:
- Reset, default W=2 -> all outputs 0; busy=0; mem_oe=mem_we=0.
- Byte read: A=0x1234, word=0, mem_din=0xA5 -> mem_addr=0x1234; mem_oe high 3 cycles after a 1-cycle SETUP; done in cycle 5; MDR_L=0xA5, MDR_H=0x00.
- Word read at wrap boundary: A=0xFFFF, mem_din=0x11 at 0xFFFF and 0x22 at 0x0000 -> two oe pulses separated by one low cycle; done in cycle 9; MDR_L=0x11, MDR_H=0x22.
- Word write: A=0x0100, IBL=0x3C, IBH=0xC3 -> first we pulse drives 0x0100/0x3C, second drives 0x0101/0xC3; mem_oe stays 0; MDR_L and MDR_H are unchanged.
- Simultaneous and mid-operation requests: rd_req=wr_req=1 -> read only. wr_req pulsed during STROBE -> ignored, exactly one cycle executes.
- Reset asserted in the second STROBE cycle of a word read -> strobes 0 on the next cycle, no done, IDLE. A fresh request afterwards completes normally with W=0 build: byte done in cycle 3.
